// File: rtl/eq_seq_cmp.sv
// eq_seq_cmp: multi-cycle magnitude/equality comparator.
//
// Compares two WIDTH-bit operands one SLICE-bit slice per clock. It starts at
// the most significant slice and stops at the first slice that differs, so
// the critical path is a SLICE-bit compare rather than a WIDTH-bit one. In
// signed mode the operands are compared as two's-complement values.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request; sampled only in IDLE
//   signed_mode  1 = two's-complement compare, 0 = unsigned; sampled with start
//   a, b         operands; sampled with start
//   busy         1 while the slice walk is running
//   done         1-cycle pulse; eq/lt/gt are valid in this cycle
//   eq, lt, gt   result flags; held until the next compare completes
module eq_seq_cmp #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int NS    = WIDTH / SLICE;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned slice comparator serves both modes.
    localparam logic [WIDTH-1:0] SIGN_MSK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             eq_q,    eq_d;
    logic             lt_q,    lt_d;
    logic             gt_q,    gt_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             load;

    logic [SLICE-1:0] a_sl, b_sl;

    assign a_sl = a_q[int'(idx_q)*SLICE +: SLICE];
    assign b_sl = b_q[int'(idx_q)*SLICE +: SLICE];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = IDX_W'(NS - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (a_sl != b_sl) begin
                    eq_d    = 1'b0;
                    lt_d    = (a_sl < b_sl);
                    gt_d    = (a_sl > b_sl);
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    // NOTE: the operand registers carry no reset; they are always loaded
    // before the FSM reads them, so a reset would only cost area and routing.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a ^ (signed_mode ? SIGN_MSK : '0);
            b_q <= b ^ (signed_mode ? SIGN_MSK : '0);
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign eq   = eq_q;
    assign lt   = lt_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_eq_seq_cmp.sv
// tb_eq_seq_cmp: directed self-checking bench for eq_seq_cmp (WIDTH=32, SLICE=8).
// Inputs are driven on the falling edge and outputs are sampled there, so the
// cycle that follows the sampling edge of start is cycle 1.
module tb_eq_seq_cmp;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [31:0] a, b;
    logic        busy, done, eq, lt, gt;

    int n_cmp;
    int n_err;

    // Results the comparator should be holding while idle.
    logic prev_eq, prev_lt, prev_gt;

    eq_seq_cmp #(.WIDTH(32), .SLICE(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One compare. Starts from a falling edge: steps into the next cycle
    // (which must be IDLE with results held), raises start there, and follows
    // the run until done. With hold_start set, start stays high and the
    // operands are scrambled during RUN; neither may affect the result.
    task automatic run_cmp(input string tag,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic sm, input int exp_cycle,
                           input logic e_eq, input logic e_lt, input logic e_gt,
                           input logic hold_start);
        int got_cycle;
        int busy_bad;
        got_cycle = 0;
        busy_bad  = 0;
        @(negedge clk);
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle held"}, {29'd0, eq, lt, gt}, {29'd0, prev_eq, prev_lt, prev_gt});
        start       = 1'b1;
        a           = va;
        b           = vb;
        signed_mode = sm;
        @(posedge clk);
        #1;
        if (hold_start) begin
            a           = ~va;
            b           = va;
            signed_mode = ~sm;
        end else begin
            start = 1'b0;
            a     = 32'hDEAD_BEEF;
            b     = 32'h0BAD_F00D;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                got_cycle = c;
                break;
            end
            if (!busy) busy_bad++;
        end
        start = 1'b0;
        check({tag, " done cycle"}, 32'(got_cycle), 32'(exp_cycle));
        check({tag, " busy during run"}, 32'(busy_bad), 32'd0);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " eq/lt/gt"}, {29'd0, eq, lt, gt}, {29'd0, e_eq, e_lt, e_gt});
        prev_eq = e_eq;
        prev_lt = e_lt;
        prev_gt = e_gt;
    endtask

    initial begin
        int spurious;
        n_cmp       = 0;
        n_err       = 0;
        prev_eq     = 1'b0;
        prev_lt     = 1'b0;
        prev_gt     = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;

        // Reset state
        #12;
        check("reset outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: equal operands, worst-case latency
        run_cmp("t1 eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);

        // 2: top slice differs; signed mode reverses the order
        run_cmp("t2 uns", 32'h8000_0000, 32'h0000_0001, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cmp("t2 sgn", 32'h8000_0000, 32'h0000_0001, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);

        // 3: bottom slice differs
        run_cmp("t3 gt", 32'h1234_5679, 32'h1234_5678, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cmp("t3 lt", 32'h1234_5678, 32'h1234_5679, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0);

        // 4: -1 > -2 signed; start held high with new operands during RUN
        run_cmp("t4 hold", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b1);

        // 5: reset in cycle 3 of an equal-operand compare aborts it
        @(negedge clk);
        check("t5 idle done", 32'(done), 32'd0);
        start       = 1'b1;
        a           = 32'hCAFE_0001;
        b           = 32'hCAFE_0001;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("t5 busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t5 reset outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        check("t5 no done after abort", 32'(spurious), 32'd0);
        prev_eq = 1'b0;
        prev_lt = 1'b0;
        prev_gt = 1'b0;
        run_cmp("t5 after", 32'h0000_0005, 32'h0000_0007, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0);

        // 6: back-to-back; the idle check at the start of the second call
        // confirms lt is held between the two done pulses
        run_cmp("t6 first", 32'h0000_0010, 32'h0000_0020, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cmp("t6 second", 32'h0000_0020, 32'h0000_0010, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0);

        // Trailing idle cycle: single done pulse and held gt
        @(negedge clk);
        check("t6 final done", 32'(done), 32'd0);
        check("t6 final held", {29'd0, eq, lt, gt}, 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
